// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the two-port data memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DMEM_DEPTH = 64;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // True when a word address falls inside the physical data memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DMEM_DEPTH);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-port winner selection. A lone requester always wins;
// when both ports request, rr_ptr breaks the tie.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 rr_ptr,
    output logic                 winner,
    output logic                 any_req
);

    // Pick the winning port from the current request vector.
    always_comb begin
        any_req = |req;
        winner  = 1'b0;
        if (req[0] && req[1]) begin
            winner = rr_ptr;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: core load/store (port 0) and debug/DMA
// (port 1) share one single-ported data memory.
// Optional feature: define DMEM_ARB_BOUNDS_EN to reject addresses at or above
// DMEM_DEPTH with an err pulse instead of a memory access.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a request; captures winner on the next edge
//   ST_ISSUE | one cycle: gnt to winner, memory strobe (or err) driven
//   ST_RESP  | one cycle: read data from memory returned on rvalid/rdata
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0]              we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata,
    output logic [NUM_PORTS-1:0]              gnt,
    output logic [NUM_PORTS-1:0]              rvalid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata,
    output logic [NUM_PORTS-1:0]              err,
    output logic                              mem_write,
    output logic                              mem_read,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata
);

    state_t              state;
    logic                rr_ptr;
    logic                cap_idx;
    logic                cap_we;
    logic                cap_oob;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                pick_win;
    logic                pick_any;
    logic                oob_now;

    dmem_rr_pick u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (pick_win),
        .any_req (pick_any)
    );

`ifdef DMEM_ARB_BOUNDS_EN
    // Out-of-range check on the address the winner is presenting right now.
    assign oob_now = ~addr_in_range(addr[pick_win]);
`else
    assign oob_now = 1'b0;
    assign err     = '0;
`endif

    // Address and write data only leave the block during ISSUE; elsewhere the
    // bus is parked at zero so the memory sees no stale values.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ST_ISSUE) begin
            mem_addr  = cap_addr;
            mem_wdata = cap_wdata;
        end
    end

    // Memory read data is registered by the memory at the end of ISSUE, so it
    // is only available during RESP and is steered to the valid port here.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata[p] = rvalid[p] ? mem_rdata : '0;
        end
    end

    // Arbiter FSM with registered grant, strobe, valid and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            cap_idx   <= 1'b0;
            cap_we    <= 1'b0;
            cap_oob   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
`ifdef DMEM_ARB_BOUNDS_EN
            err       <= '0;
`endif
        end else begin
            gnt       <= '0;
            rvalid    <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
`ifdef DMEM_ARB_BOUNDS_EN
            err       <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        cap_idx       <= pick_win;
                        cap_we        <= we[pick_win];
                        cap_oob       <= oob_now;
                        cap_addr      <= addr[pick_win];
                        cap_wdata     <= wdata[pick_win];
                        rr_ptr        <= ~pick_win;
                        gnt[pick_win] <= 1'b1;
                        mem_write     <= we[pick_win] & ~oob_now;
                        mem_read      <= ~we[pick_win] & ~oob_now;
`ifdef DMEM_ARB_BOUNDS_EN
                        err[pick_win] <= oob_now;
`endif
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cap_we || cap_oob) begin
                        state <= ST_IDLE;
                    end else begin
                        rvalid[cap_idx] <= 1'b1;
                        state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 req  in  2  per-port request; bit 0 = core load/store, bit 1 = debug/DMA.
REQ-004 we  in  2  per-port write enable; 1 = write, 0 = read.
REQ-005 addr  in  2x32  per-port word address.
REQ-006 wdata  in  2x32  per-port write data.
REQ-007 gnt  out  2  one-cycle grant pulse to the port being serviced.
REQ-008 rvalid  out  2  one-cycle read-data-valid pulse per port.
REQ-009 rdata  out  2x32  per-port read data, meaningful only while that port's rvalid is 1.
REQ-010 err  out  2  per-port out-of-range pulse; see Configuration.
REQ-011 mem_write, mem_read  out  1 each  data memory strobes; never both 1 in the same cycle.
REQ-012 mem_addr, mem_wdata  out  32 each  data memory address and write data.
REQ-013 mem_rdata  in  32  memory read data, registered by the memory on the edge ending a mem_read cycle.

Function
REQ-014 FSM states are IDLE, ISSUE and RESP.
REQ-015 IDLE: if any req bit is 1 at an edge, capture winner index, we, addr and wdata; go to ISSUE. Otherwise stay in IDLE.
REQ-016 Winner rules: if only one req bit is set, that port wins. If both are set, the port pointed to by rr_ptr wins.
REQ-017 rr_ptr updates on every capture to the non-winning port. Reset value is 0.
REQ-018 ISSUE lasts exactly one cycle:
- gnt[winner]=1.
- mem_addr and mem_wdata come from the captured registers.
- mem_write = captured we; mem_read = !captured we.
REQ-019 ISSUE exit: captured write goes to IDLE; captured read goes to RESP.
REQ-020 RESP lasts exactly one cycle: rvalid[winner]=1 and rdata[winner]=mem_rdata, then go to IDLE.
REQ-021 Latency from the capture edge: write grant in cycle +1; read grant in cycle +1, read data in cycle +2. Throughput is one write per 2 cycles or one read per 3 cycles.
REQ-022 Requester holds req, we, addr and wdata stable until it sees gnt. A req still high after its gnt cycle is a new request.
REQ-023 No cancellation: once captured, a transaction completes even if req drops.
REQ-024 Outside ISSUE, mem_write=mem_read=0. Outside RESP, rvalid=0. rdata of a non-valid port is 0.
REQ-025 At most one gnt bit and one rvalid bit is set in any cycle.

Reset
REQ-026 Reset at any edge forces state=IDLE and rr_ptr=0, and clears the captured registers.
REQ-027 Reset in the same edge as a request wins: nothing is captured.
REQ-028 Reset during ISSUE or RESP aborts the transaction: no further gnt or rvalid, and mem strobes are low in the next cycle.
REQ-029 All outputs are 0 while the state is IDLE after reset.

Configuration
REQ-030 Macro DMEM_ARB_BOUNDS_EN defined: a captured addr >= DMEM_DEPTH (64) still pulses gnt[winner] in ISSUE, together with err[winner]=1.
- mem_write and mem_read stay 0.
- No RESP state and no rvalid follow.
- FSM returns to IDLE.
REQ-031 Macro DMEM_ARB_BOUNDS_EN not defined: err is tied to 0 and all addresses pass through unchecked.

Structure
REQ-032 Package dmem_arb_pkg holds the state enum typedef, NUM_PORTS=2, DMEM_DEPTH=64 and ADDR_W=DATA_W=32.
REQ-033 One sub-module, dmem_rr_pick, is purely combinational: inputs req[1:0] and rr_ptr; outputs winner index and any_req.

Verification
REQ-034 Single write: port0 writes addr=8, wdata=32'hABCD_1234.
- Expect gnt[0] one cycle later, with mem_write=1 and mem_addr=8 in the same cycle.
- Expect no rvalid.
REQ-035 Readback: port1 reads addr=8 after REQ-034.
- Expect gnt[1] at +1.
- Expect rvalid[1]=1 and rdata[1]=32'hABCD_1234 at +2.
REQ-036 Contention: both ports hold req continuously (reads, addr 4 and 5) from reset. Expect grants in order 0,1,0,1, each rvalid on the matching port.
REQ-037 Reset mid-read: assert reset during RESP. Expect rvalid=0 in the next cycle, state IDLE, and the next contention won by port 0.
REQ-038 With DMEM_ARB_BOUNDS_EN: port0 writes addr=64.
- Expect gnt[0]=1, err[0]=1, mem_write=0.
- A following read of addr=0 returns its prior value unchanged.
REQ-039 Invariant checks every cycle: onehot0(gnt), onehot0(rvalid), !(mem_write && mem_read).
